// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the oversampling UART receiver:
//                receiver FSM state encoding, parameter legality bounds and
//                a parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Legal ranges for the receiver parameters
    localparam int C_DATA_W_MIN = 5;
    localparam int C_DATA_W_MAX = 9;
    localparam int C_OVS_MIN    = 8;
    localparam int C_OVS_MAX    = 32;

    // Receiver FSM states; PARITY is only visited when parity checking is built in
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    // Parity bit a transmitter would send for this word (data is zero-extended)
    function automatic logic calc_parity(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Single-clock synchronous receive FIFO. Simultaneous push and
//                pop always succeed, even when full. A push into a full FIFO
//                without a pop is dropped and flagged on drop_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_rd;
    logic w_do_wr;

    assign w_full  = (r_count == C_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_do_rd = rd_en_i && !w_empty;
    assign w_do_wr = wr_en_i && (!w_full || w_do_rd);

    assign drop_o  = wr_en_i && w_full && !w_do_rd;
    assign valid_o = !w_empty;
    assign full_o  = w_full;
    assign count_o = r_count;
    assign data_o  = w_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array: written only on an accepted push
    always_ff @(posedge clk_i) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); occupancy tracks push/pop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_n.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_n
//  Description : Oversampling UART receiver with a programmable baud divider,
//                glitch-rejecting start detection, break handling and a
//                receive FIFO with sticky overrun.
//                Optional parity checking is built when the macro
//                UART_RX_PARITY_EN is defined (adds port parity_odd_i).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_n
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OVS    = 16,
    parameter int DEPTH  = 8,
    parameter int DIV_W  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   rx_i,
    input  logic [DIV_W-1:0]       baud_div_i,
`ifdef UART_RX_PARITY_EN
    input  logic                   parity_odd_i,
`endif
    input  logic                   rd_en_i,
    output logic [DATA_W-1:0]      data_o,
    output logic                   valid_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   frame_err_o,
    output logic                   parity_err_o,
    output logic                   overrun_o,
    output logic                   busy_o
);

    localparam int C_SMP_W = $clog2(OVS);
    localparam int C_BIT_W = $clog2(DATA_W);

    localparam logic [C_SMP_W-1:0] C_SMP_HALF = C_SMP_W'(OVS / 2 - 1);
    localparam logic [C_SMP_W-1:0] C_SMP_LAST = C_SMP_W'(OVS - 1);
    localparam logic [C_BIT_W-1:0] C_BIT_LAST = C_BIT_W'(DATA_W - 1);

    // Line synchroniser and edge history
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;

    // Baud tick generation
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;

    // Receiver state
    rx_state_e          r_state;
    logic [C_SMP_W-1:0] r_smp_cnt;
    logic [C_BIT_W-1:0] r_bit_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic               r_push;
    logic               r_frame_err;
    logic               r_busy;
    logic               r_overrun;
    logic               w_start_det;
    logic               w_drop;

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;
`endif

    assign w_start_det = (r_state == ST_IDLE) && r_rx_prev && !r_rx_sync;
    assign w_tick      = (r_state != ST_IDLE) && (r_div_cnt == r_div);

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Oversample tick divider; divisor captured at start so mid-frame changes are ignored
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div     <= '0;
            r_div_cnt <= '0;
        end else if (w_start_det) begin
            r_div     <= baud_div_i;
            r_div_cnt <= '0;
        end else if ((r_state == ST_IDLE) || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Frame FSM: start validation at mid start bit, then one sample per bit at mid-bit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_smp_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_start_det) begin
                        r_state   <= ST_START;
                        r_smp_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_smp_cnt == C_SMP_HALF) begin
                            r_smp_cnt <= '0;
                            if (r_rx_sync) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= ST_DATA;
                            end
                        end else begin
                            r_smp_cnt <= r_smp_cnt + C_SMP_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_smp_cnt == C_SMP_LAST) begin
                            r_smp_cnt <= '0;
                            r_shift   <= {r_rx_sync, r_shift[DATA_W-1:1]};
                            if (r_bit_cnt == C_BIT_LAST) begin
                                r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                                r_state   <= ST_PARITY;
`else
                                r_state   <= ST_STOP;
`endif
                            end else begin
                                r_bit_cnt <= r_bit_cnt + C_BIT_W'(1);
                            end
                        end else begin
                            r_smp_cnt <= r_smp_cnt + C_SMP_W'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        if (r_smp_cnt == C_SMP_LAST) begin
                            r_smp_cnt <= '0;
                            r_par_bit <= r_rx_sync;
                            r_state   <= ST_STOP;
                        end else begin
                            r_smp_cnt <= r_smp_cnt + C_SMP_W'(1);
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (w_tick) begin
                        if (r_smp_cnt == C_SMP_LAST) begin
                            r_smp_cnt <= '0;
                            if (r_rx_sync) begin
`ifdef UART_RX_PARITY_EN
                                if (calc_parity(9'(r_shift), parity_odd_i) != r_par_bit) begin
                                    r_parity_err <= 1'b1;
                                end else begin
                                    r_push <= 1'b1;
                                end
`else
                                r_push  <= 1'b1;
`endif
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= ST_BREAK;
                            end
                        end else begin
                            r_smp_cnt <= r_smp_cnt + C_SMP_W'(1);
                        end
                    end
                end
                ST_BREAK: begin
                    if (r_rx_sync) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Overrun stays set from the first dropped word until reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end
    end

    uart_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (r_push),
        .wr_data_i (r_shift),
        .rd_en_i   (rd_en_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .full_o    (full_o),
        .count_o   (count_o),
        .drop_o    (w_drop)
    );

    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;
    assign busy_o      = r_busy;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = r_parity_err;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule
`default_nettype wire
